// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input-side conditioning blocks.
//   - 2-bit state encodings for the push-button debounce FSM
//   - typedef enum built on those encodings
//   - cnt_width(): width of the debounce counter for a given cycle count
package input_conditioner_pkg;

  localparam logic [1:0] S_RELEASED     = 2'b00;
  localparam logic [1:0] S_PRESS_WAIT   = 2'b01;
  localparam logic [1:0] S_PRESSED      = 2'b10;
  localparam logic [1:0] S_RELEASE_WAIT = 2'b11;

  typedef enum logic [1:0] {
    RELEASED     = S_RELEASED,
    PRESS_WAIT   = S_PRESS_WAIT,
    PRESSED      = S_PRESSED,
    RELEASE_WAIT = S_RELEASE_WAIT
  } btn_state_e;

  // The counter only ever holds 0..n-1, so clog2(n) bits suffice; never
  // return a zero width.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-flop synchronizer, 4-state debounce FSM and
// saturating stability counter.
// Ports:
//   clock   : system clock, rising edge
//   reset   : asynchronous, active-low
//   btn_i   : raw, asynchronous, bouncing button level (1 = pressed)
//   press_o : registered one-cycle pulse following a debounced press
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             st_q, st_d;
  logic             press_q, press_d;
  logic             s;

  assign s       = sync_q[1];
  assign press_o = press_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      state_q <= RELEASED;
      cnt_q   <= '0;
      st_q    <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      press_q <= press_d;
    end
  end

  // The wait states compare s against the accepted level st_q, so press and
  // release share one mirrored set of transitions.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    press_d = 1'b0;
    unique case (state_q)
      RELEASED, PRESSED: begin
        if (s != st_q) begin
          state_d = st_q ? RELEASE_WAIT : PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_WAIT, RELEASE_WAIT: begin
        if (s == st_q) begin
          // bounce: fall back to the accepted level
          state_d = st_q ? PRESSED : RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = st_q ? RELEASED : PRESSED;
          cnt_d   = '0;
          st_d    = ~st_q;
          press_d = ~st_q;  // only a completed press raises an event
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw board inputs for the ALU top.
// Ports:
//   clock     : system clock, rising edge
//   reset     : asynchronous, active-low
//   i_SWs     : raw slide-switch levels (N_BITS)
//   i_buttons : raw bouncing push-button levels (N_B, 1 = pressed)
//   o_SWs     : switch levels after a 2-flop synchronizer (no debounce)
//   o_buttons : registered single-cycle press pulses, at most one bit high
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_BITS          = 6,
  parameter int N_B             = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_BITS-1:0] i_SWs,
  input  logic [N_B-1:0]    i_buttons,
  output logic [N_BITS-1:0] o_SWs,
  output logic [N_B-1:0]    o_buttons
);

  logic [N_BITS-1:0] sw_meta_q, sw_sync_q;
  logic [N_B-1:0]    press_raw;
  logic [N_B-1:0]    btn_q, btn_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= i_SWs;
      sw_sync_q <= sw_meta_q;
    end
  end

  assign o_SWs = sw_sync_q;

  for (genvar k = 0; k < N_B; k++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .btn_i  (i_buttons[k]),
      .press_o(press_raw[k])
    );
  end

  // Highest-index event wins; simultaneous lower events are dropped.
  always_comb begin
    btn_d = '0;
    for (int k = 0; k < N_B; k++) begin
      if (press_raw[k]) begin
        btn_d    = '0;
        btn_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_q <= '0;
    end else begin
      btn_q <= btn_d;
    end
  end

  assign o_buttons = btn_q;

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] i_SWs = '0;
  logic [2:0] i_buttons = '0;
  logic [5:0] o_SWs;
  logic [2:0] o_buttons;

  int n_cmp = 0;
  int n_err = 0;

  input_conditioner #(
    .N_BITS(6),
    .N_B(3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .i_SWs    (i_SWs),
    .i_buttons(i_buttons),
    .o_SWs    (o_SWs),
    .o_buttons(o_buttons)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Steps 'last' cycles checking o_buttons each time: pat at step 'at', else 0.
  task automatic expect_pulse(input string tag, input logic [2:0] pat, input int at, input int last);
    for (int i = 1; i <= last; i++) begin
      step();
      chk(tag, {5'b0, o_buttons}, (i == at) ? {5'b0, pat} : 8'h00);
    end
  endtask

  initial begin
    // reset state
    #2 reset = 1'b0;
    i_SWs = 6'h3F;
    #1;
    chk("rst_sw", {2'b0, o_SWs}, 8'h00);
    chk("rst_btn", {5'b0, o_buttons}, 8'h00);
    step();
    step();
    step();
    chk("rst_sw_held", {2'b0, o_SWs}, 8'h00);
    chk("rst_btn_held", {5'b0, o_buttons}, 8'h00);

    // switch synchronizer latency
    reset = 1'b1;
    i_SWs = 6'h2A;
    step();
    chk("sw_lat1", {2'b0, o_SWs}, 8'h00);
    step();
    chk("sw_lat2", {2'b0, o_SWs}, 8'h2A);

    // clean press of button 1, held; release makes no event
    i_buttons = 3'b010;
    expect_pulse("clean", 3'b010, 7, 10);
    i_buttons = 3'b000;
    expect_pulse("clean_rel", 3'b000, 0, 10);

    // bounce on button 0, then stable hold
    i_buttons = 3'b001; step(); chk("bnc_a", {5'b0, o_buttons}, 8'h00);
    i_buttons = 3'b000; step(); chk("bnc_b", {5'b0, o_buttons}, 8'h00);
    i_buttons = 3'b001; step(); chk("bnc_c", {5'b0, o_buttons}, 8'h00);
    i_buttons = 3'b000; step(); chk("bnc_d", {5'b0, o_buttons}, 8'h00);
    i_buttons = 3'b001;
    expect_pulse("bounce", 3'b001, 7, 10);
    i_buttons = 3'b000;
    expect_pulse("bnc_rel", 3'b000, 0, 10);

    // simultaneous press of 2 and 0: only 2 reported
    i_buttons = 3'b101;
    expect_pulse("simul", 3'b100, 7, 10);
    i_buttons = 3'b100;
    expect_pulse("simul_rel0", 3'b000, 0, 10);
    i_buttons = 3'b101;
    expect_pulse("repress0", 3'b001, 7, 10);
    i_buttons = 3'b000;
    expect_pulse("simul_rel", 3'b000, 0, 10);

    // reset during PRESS_WAIT of button 2, held through deassertion
    i_buttons = 3'b100;
    step(); step(); step(); step();
    chk("mid_pre", {5'b0, o_buttons}, 8'h00);
    reset = 1'b0;
    #1;
    chk("mid_rst_btn", {5'b0, o_buttons}, 8'h00);
    chk("mid_rst_sw", {2'b0, o_SWs}, 8'h00);
    expect_pulse("mid_rst_hold", 3'b000, 0, 8);
    reset = 1'b1;
    expect_pulse("post_rst", 3'b100, 7, 10);
    chk("post_rst_sw", {2'b0, o_SWs}, 8'h2A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
